// File: rtl/pwl_delay_ctrl_if.sv
// rtl/pwl_delay_ctrl_if.sv - request/status bundle between calibration logic and pwl_delay_ctrl
interface pwl_delay_ctrl_if #(
  parameter int CODE_W = 6
);
  logic              req;
  logic [CODE_W-1:0] target;
  logic              freeze;
  logic              ack;
  logic              busy;
  logic              settled;
  logic [CODE_W-1:0] code;
  real               delay;

  modport master (
    output req, target, freeze,
    input  ack, busy, settled, code, delay
  );

  modport slave (
    input  req, target, freeze,
    output ack, busy, settled, code, delay
  );
endinterface

// File: rtl/pwl_delay_ctrl.sv
// rtl/pwl_delay_ctrl.sv - slews the pwl delay code one LSB per dwell period toward a requested target
module pwl_delay_ctrl #(
  parameter int  CODE_W    = 6,
  parameter int  CODE_MAX  = 63,
  parameter int  INIT_CODE = 8,
  parameter real T_MIN     = 10e-12,
  parameter real T_LSB     = 1e-12,
  parameter int  DWELL     = 4
) (
  input  logic             clk,
  input  logic             rst,
  pwl_delay_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int                CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [CODE_W-1:0] MAX_C      = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] INIT_C     = CODE_W'(INIT_CODE);

  state_t            state_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] tgt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q;
  logic              busy_q;
  logic              settled_q;
  logic [CODE_W-1:0] tgt_clamp;
  logic [CODE_W-1:0] code_step;

  // In RUN code never equals tgt_q, so the step cannot wrap past either end.
  always_comb begin
    tgt_clamp = (bus.target > MAX_C) ? MAX_C : bus.target;
    code_step = (tgt_q > code_q) ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= INIT_C;
      tgt_q     <= INIT_C;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            tgt_q <= tgt_clamp;
            ack_q <= 1'b1;
            if (tgt_clamp != code_q) begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              settled_q <= 1'b0;
              cnt_q     <= '0;
            end
          end
        end
        RUN: begin
          if (!bus.freeze) begin
            if (cnt_q == '0) begin
              code_q <= code_step;
              cnt_q  <= CNT_RELOAD;
              if (code_step == tgt_q) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                settled_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.settled = settled_q;
  assign bus.code    = code_q;
  // delay tracks code combinationally so both change on the same edge.
  assign bus.delay   = T_MIN + real'(int'(code_q)) * T_LSB;

endmodule

// File: tb/tb_pwl_delay_ctrl.sv
// tb/tb_pwl_delay_ctrl.sv - directed and randomized checks of pwl_delay_ctrl against a step-schedule model
module tb_pwl_delay_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [5:0] target = '0;
  logic       freeze = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pwl_delay_ctrl_if #(.CODE_W(6)) if0 ();
  pwl_delay_ctrl_if #(.CODE_W(6)) if1 ();
  pwl_delay_ctrl_if #(.CODE_W(6)) if2 ();

  assign if0.req = req;  assign if0.target = target;  assign if0.freeze = freeze;
  assign if1.req = req;  assign if1.target = target;  assign if1.freeze = freeze;
  assign if2.req = req;  assign if2.target = target;  assign if2.freeze = freeze;

  pwl_delay_ctrl #(.CODE_W(6), .CODE_MAX(63), .INIT_CODE(8), .T_MIN(10e-12), .T_LSB(1e-12), .DWELL(4))
    u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  pwl_delay_ctrl #(.CODE_W(6), .CODE_MAX(63), .INIT_CODE(8), .T_MIN(10e-12), .T_LSB(1e-12), .DWELL(1))
    u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  pwl_delay_ctrl #(.CODE_W(6), .CODE_MAX(40), .INIT_CODE(8), .T_MIN(10e-12), .T_LSB(1e-12), .DWELL(3))
    u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint to_fs(input real r);
    return longint'($rtoi(r * 1e15 + 0.5));
  endfunction

  function automatic int p_max(input int i);
    return (i == 2) ? 40 : 63;
  endfunction

  function automatic int p_dwell(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 3);
  endfunction

  // Model: a ramp is a schedule of step edges; freeze postpones the pending step by one edge.
  int m_code [3];
  int m_tgt  [3];
  int m_next [3];
  bit m_run  [3];
  bit m_ack  [3];
  int n_edge = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_code[i] = 8; m_tgt[i] = 8; m_next[i] = 0; m_run[i] = 0; m_ack[i] = 0;
      end
    end else begin
      n_edge++;
      for (int i = 0; i < 3; i++) begin
        m_ack[i] = 0;
        if (m_run[i]) begin
          if (freeze) begin
            m_next[i]++;
          end else if (n_edge == m_next[i]) begin
            m_code[i] += (m_tgt[i] > m_code[i]) ? 1 : -1;
            m_next[i] = n_edge + p_dwell(i);
            if (m_code[i] == m_tgt[i]) m_run[i] = 0;
          end
        end else if (req) begin
          m_tgt[i] = (int'(target) > p_max(i)) ? p_max(i) : int'(target);
          m_ack[i] = 1;
          if (m_tgt[i] != m_code[i]) begin
            m_run[i] = 1;
            m_next[i] = n_edge + 1;
          end
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic [5:0] c, input logic b, input logic s,
                          input logic a, input real d);
    check($sformatf("m%0d_code", i), longint'(c), longint'(m_code[i]));
    check($sformatf("m%0d_busy", i), longint'(b), longint'(m_run[i]));
    check($sformatf("m%0d_settled", i), longint'(s), longint'(m_code[i] == m_tgt[i]));
    check($sformatf("m%0d_ack", i), longint'(a), longint'(m_ack[i]));
    check($sformatf("m%0d_delay_fs", i), to_fs(d), to_fs(10e-12 + real'(m_code[i]) * 1e-12));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, if0.code, if0.busy, if0.settled, if0.ack, if0.delay);
    cmp_inst(1, if1.code, if1.busy, if1.settled, if1.ack, if1.delay);
    cmp_inst(2, if2.code, if2.busy, if2.settled, if2.ack, if2.delay);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; freeze = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int acks;
    int max2;
    bit done;

    #1 rst = 1'b1;
    step();
    check("rst_code", longint'(if0.code), 8);
    check("rst_delay_fs", to_fs(if0.delay), 18000);
    check("rst_settled", longint'(if0.settled), 1);
    check("rst_busy", longint'(if0.busy), 0);
    check("rst_ack", longint'(if0.ack), 0);
    rst = 1'b0;
    step();

    // Up-ramp 8 -> 12 with DWELL=4.
    req = 1'b1; target = 6'd12;
    step();
    check("up_ack_e0", longint'(if0.ack), 1);
    check("up_busy_e0", longint'(if0.busy), 1);
    req = 1'b0;
    step();
    check("up_code_e1", longint'(if0.code), 9);
    check("up_ack_e1", longint'(if0.ack), 0);
    repeat (3) step();
    check("up_code_e4", longint'(if0.code), 9);
    step();
    check("up_code_e5", longint'(if0.code), 10);
    repeat (4) step();
    check("up_code_e9", longint'(if0.code), 11);
    repeat (3) step();
    check("up_busy_e12", longint'(if0.busy), 1);
    step();
    check("up_code_e13", longint'(if0.code), 12);
    check("up_busy_e13", longint'(if0.busy), 0);
    check("up_settled_e13", longint'(if0.settled), 1);
    check("up_delay_e13", to_fs(if0.delay), 22000);

    // Down-ramp 8 -> 5 with DWELL=1.
    do_reset();
    req = 1'b1; target = 6'd5;
    step();
    req = 1'b0;
    step();
    check("dn_code_e1", longint'(if1.code), 7);
    check("dn_delay_e1", to_fs(if1.delay), 17000);
    step();
    check("dn_code_e2", longint'(if1.code), 6);
    check("dn_delay_e2", to_fs(if1.delay), 16000);
    step();
    check("dn_code_e3", longint'(if1.code), 5);
    check("dn_delay_e3", to_fs(if1.delay), 15000);
    check("dn_settled_e3", longint'(if1.settled), 1);

    // Target equal to the current code.
    do_reset();
    req = 1'b1; target = 6'd8;
    step();
    check("eq_ack", longint'(if0.ack), 1);
    check("eq_busy", longint'(if0.busy), 0);
    check("eq_settled", longint'(if0.settled), 1);
    req = 1'b0;
    step();
    check("eq_ack_gone", longint'(if0.ack), 0);
    check("eq_code", longint'(if0.code), 8);
    check("eq_delay", to_fs(if0.delay), 18000);

    // Clamp at CODE_MAX=40.
    do_reset();
    req = 1'b1; target = 6'd63;
    step();
    req = 1'b0;
    max2 = 0; done = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (int'(if2.code) > max2) max2 = int'(if2.code);
      if (!if2.busy) begin
        done = 1;
        break;
      end
    end
    check("clamp_done", longint'(done), 1);
    check("clamp_code", longint'(if2.code), 40);
    check("clamp_max", longint'(max2), 40);
    check("clamp_settled", longint'(if2.settled), 1);

    // Freeze for six edges mid-ramp.
    do_reset();
    req = 1'b1; target = 6'd12;
    step();
    req = 1'b0;
    step();
    freeze = 1'b1;
    repeat (6) step();
    check("frz_code_hold", longint'(if0.code), 9);
    freeze = 1'b0;
    repeat (3) step();
    check("frz_code_e10", longint'(if0.code), 9);
    step();
    check("frz_code_e11", longint'(if0.code), 10);
    repeat (4) step();
    check("frz_code_e15", longint'(if0.code), 11);

    // Request held through a ramp.
    do_reset();
    req = 1'b1; target = 6'd10;
    step();
    check("hold_ack_e0", longint'(if0.ack), 1);
    acks = 0;
    repeat (5) begin
      step();
      acks += int'(if0.ack);
    end
    check("hold_no_ack", longint'(acks), 0);
    check("hold_code_e5", longint'(if0.code), 10);
    check("hold_busy_e5", longint'(if0.busy), 0);
    step();
    check("hold_ack_e6", longint'(if0.ack), 1);
    req = 1'b0;

    // Reset mid-ramp takes effect without a clock edge.
    do_reset();
    req = 1'b1; target = 6'd20;
    step();
    req = 1'b0;
    repeat (3) step();
    check("mid_code_pre", longint'(if0.code), 9);
    rst = 1'b1;
    #1;
    check("mid_rst_code", longint'(if0.code), 8);
    check("mid_rst_busy", longint'(if0.busy), 0);
    check("mid_rst_ack", longint'(if0.ack), 0);
    check("mid_rst_delay", to_fs(if0.delay), 18000);
    step();
    rst = 1'b0;
    step();

    // Randomized traffic; the model comparison runs every cycle.
    for (int k = 0; k < 3000; k++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      req    = ($urandom_range(0, 3) == 0);
      target = 6'($urandom_range(0, 63));
      freeze = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
